// File: rtl/activity_pkg.sv
// Shared definitions for the activity LED scheduler: FSM encoding, slot-width helper
// and default timing constants.
package activity_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SLOT_ON   = 2'd1,
        SLOT_GAP  = 2'd2,
        FRAME_GAP = 2'd3
    } state_t;

    localparam int DEF_N                = 4;
    localparam int DEF_ON_CYCLES        = 4194304;
    localparam int DEF_GAP_CYCLES       = 4194304;
    localparam int DEF_FRAME_GAP_CYCLES = 16777216;
    localparam int DEF_CW               = 25;

    // Width needed to index 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/activity_edge_sync.sv
// One activity channel: two-flop synchronizer, edge register and a sticky
// transition flag whose set takes priority over a simultaneous clear.
module activity_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic x,
    input  logic clear,
    output logic sticky
);

    logic meta_reg;
    logic sync_reg;
    logic edge_reg;
    logic sticky_reg;
    logic act;

    assign act    = sync_reg ^ edge_reg;
    assign sticky = sticky_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            edge_reg   <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            meta_reg <= x;
            sync_reg <= meta_reg;
            edge_reg <= sync_reg;
            if (act) begin
                sticky_reg <= 1'b1;
            end else if (clear) begin
                sticky_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/activity_led_scheduler.sv
// Time-division blink scheduler sharing one LED among N activity sources.
// Define ACTIVITY_LED_HEARTBEAT_EN to light a short heartbeat at each frame-gap start.
module activity_led_scheduler
    import activity_pkg::*;
#(
    parameter int N                = DEF_N,
    parameter int ON_CYCLES        = DEF_ON_CYCLES,
    parameter int GAP_CYCLES       = DEF_GAP_CYCLES,
    parameter int FRAME_GAP_CYCLES = DEF_FRAME_GAP_CYCLES,
    parameter int CW               = DEF_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          x,
    input  logic                  enable,
    output logic                  led,
    output logic [clog2(N)-1:0]   slot,
    output logic                  frame_start
);

    localparam int SW = clog2(N);
    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FG_LAST   = CW'(FRAME_GAP_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] timer_reg, timer_next;
    logic [SW-1:0] slot_reg, slot_next;
    logic          lit_reg, lit_next;
    logic          led_reg, led_next;
    logic          fs_reg, fs_next;
    logic          enter_on;
    logic [N-1:0]  clear;
    logic [N-1:0]  sticky;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            localparam logic [SW-1:0] IDX = SW'(gi);
            assign clear[gi] = enter_on && (slot_next == IDX);
            activity_edge_sync u_sync (
                .clk    (clk),
                .reset  (reset),
                .x      (x[gi]),
                .clear  (clear[gi]),
                .sticky (sticky[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg + 1'b1;
        slot_next  = slot_reg;
        enter_on   = 1'b0;
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (enable) begin
                    state_next = SLOT_ON;
                    slot_next  = '0;
                    enter_on   = 1'b1;
                end
            end
            SLOT_ON: begin
                if (timer_reg == ON_LAST) begin
                    state_next = SLOT_GAP;
                    timer_next = '0;
                end
            end
            SLOT_GAP: begin
                if (timer_reg == GAP_LAST) begin
                    timer_next = '0;
                    if (slot_reg == SLOT_LAST) begin
                        state_next = FRAME_GAP;
                    end else begin
                        state_next = SLOT_ON;
                        slot_next  = slot_reg + 1'b1;
                        enter_on   = 1'b1;
                    end
                end
            end
            FRAME_GAP: begin
                if (timer_reg == FG_LAST) begin
                    timer_next = '0;
                    if (enable) begin
                        state_next = SLOT_ON;
                        slot_next  = '0;
                        enter_on   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase

        // lit captures the flag before this cycle's set so a coincident edge waits a frame
        lit_next = enter_on ? sticky[slot_next] : lit_reg;
        fs_next  = enter_on && (slot_next == '0);

        led_next = 1'b0;
        case (state_reg)
            SLOT_ON:   led_next = lit_reg;
`ifdef ACTIVITY_LED_HEARTBEAT_EN
            FRAME_GAP: led_next = (32'(timer_reg) < HB_CYCLES);
`endif
            default:   led_next = 1'b0;
        endcase
    end

`ifdef ACTIVITY_LED_HEARTBEAT_EN
    localparam int HB_RAW    = ON_CYCLES / 4;
    localparam int HB_CYCLES = (HB_RAW < FRAME_GAP_CYCLES) ? HB_RAW : FRAME_GAP_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            slot_reg  <= '0;
            lit_reg   <= 1'b0;
            led_reg   <= 1'b0;
            fs_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            slot_reg  <= slot_next;
            lit_reg   <= lit_next;
            led_reg   <= led_next;
            fs_reg    <= fs_next;
        end
    end

    assign led         = led_reg;
    assign slot        = slot_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_activity_led_scheduler.sv
// Directed bench for activity_led_scheduler with N=4, ON=4, GAP=3, FRAME_GAP=5.
// Frame-relative cycle k=0 is the first sample where frame_start is high.
module tb_activity_led_scheduler;

    localparam int N     = 4;
    localparam int ON    = 4;
    localparam int GAP   = 3;
    localparam int FG    = 5;
    localparam int CW    = 4;
    localparam int PITCH = ON + GAP;
    localparam int FRAME = N * PITCH + FG;
`ifdef ACTIVITY_LED_HEARTBEAT_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] x;
    logic         enable;
    logic         led;
    logic [1:0]   slot;
    logic         frame_start;

    int vectors = 0;
    int errors  = 0;
    int waited;

    always #5 clk = ~clk;

    activity_led_scheduler #(
        .N(N), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .FRAME_GAP_CYCLES(FG), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .enable(enable),
        .led(led), .slot(slot), .frame_start(frame_start)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(input string name, output int n);
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME) begin
            step;
            n++;
        end
        chk({name, "_fs_seen"}, {7'd0, frame_start}, 8'd1);
    endtask

    // Checks one frame starting at k=0; optionally toggles x bits or drops enable at a given k.
    task automatic check_frame(input logic [N-1:0] mask, input int tog_k,
                               input logic [N-1:0] tog_bits, input int drop_k,
                               input string name);
        logic exp_led;
        for (int k = 0; k < FRAME; k++) begin
            exp_led = 1'b0;
            for (int s = 0; s < N; s++) begin
                if (mask[s] && k >= PITCH * s + 1 && k <= PITCH * s + ON) exp_led = 1'b1;
            end
            if (HB && k == N * PITCH + 1) exp_led = 1'b1;
            chk({name, "_led"}, {7'd0, led}, {7'd0, exp_led});
            chk({name, "_fs"}, {7'd0, frame_start}, {7'd0, (k == 0)});
            if (k < N * PITCH) chk({name, "_slot"}, {6'd0, slot}, 8'(k / PITCH));
            if (k == tog_k) x = x ^ tog_bits;
            if (k == drop_k) enable = 1'b0;
            step;
        end
        chk({name, "_next_fs"}, {7'd0, frame_start}, {7'd0, enable});
    endtask

    initial begin
        x      = '0;
        enable = 1'b0;
        reset  = 1'b1;
        step; step; step;
        chk("rst_led", {7'd0, led}, 8'd0);
        chk("rst_slot", {6'd0, slot}, 8'd0);
        chk("rst_fs", {7'd0, frame_start}, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("idle_led", {7'd0, led}, 8'd0);
            chk("idle_fs", {7'd0, frame_start}, 8'd0);
        end

        enable = 1'b1;
        wait_fs("start", waited);
        chk("start_latency", 8'(waited), 8'd1);
        check_frame(4'b0000, -1, 4'b0000, -1, "dark0");
        check_frame(4'b0000, -1, 4'b0000, -1, "dark1");
        check_frame(4'b0000, 29, 4'b0100, -1, "tog2");
        check_frame(4'b0100, -1, 4'b0000, -1, "show2");
        check_frame(4'b0000, -1, 4'b0000, -1, "after2");

        // x[1] driven at k=4 so its act pulse coincides with the slot-1 entry clear
        check_frame(4'b0000, 4, 4'b0010, -1, "setwin");
        check_frame(4'b0010, -1, 4'b0000, 9, "show1_drop");

        for (int i = 0; i < 8; i++) begin
            chk("hold_led", {7'd0, led}, 8'd0);
            chk("hold_fs", {7'd0, frame_start}, 8'd0);
            if (i == 1) x = x ^ 4'b1000;
            step;
        end
        enable = 1'b1;
        wait_fs("resume", waited);
        chk("resume_latency", 8'(waited), 8'd1);
        check_frame(4'b1000, 29, 4'b0001, -1, "show3");

        // slot 0 is lit this frame; x[2] toggle becomes pending before reset hits
        chk("lit0_fs", {7'd0, frame_start}, 8'd1);
        x = x ^ 4'b0100;
        step;
        chk("lit0_led_k1", {7'd0, led}, 8'd1);
        step;
        chk("lit0_led_k2", {7'd0, led}, 8'd1);
        step;
        chk("lit0_led_k3", {7'd0, led}, 8'd1);
        reset = 1'b1;
        x     = '0;
        step;
        chk("midrst_led", {7'd0, led}, 8'd0);
        chk("midrst_slot", {6'd0, slot}, 8'd0);
        chk("midrst_fs", {7'd0, frame_start}, 8'd0);
        step; step;
        reset = 1'b0;
        wait_fs("postrst", waited);
        chk("postrst_latency", 8'(waited), 8'd1);
        check_frame(4'b0000, -1, 4'b0000, -1, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
